// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer.
// Streams WORDS 32-bit words, least-significant first, through one shared
// 32-bit add/sub unit. The carry is chained between words, and the wide
// result is assembled with ARM-style N/Z/C/V flags.
module mp_addsub_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic                  rev,
  input  logic                  use_carry,
  input  logic                  c_flag_in,
  input  logic                  flush,
  input  logic [WORDS*32-1:0]   a_in,
  input  logic [WORDS*32-1:0]   b_in,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_c_in,
  output logic                  add_op,
  output logic                  add_rev,
  input  logic [31:0]           add_s,
  input  logic                  add_c_out,
  output logic                  busy,
  output logic                  done,
  output logic [WORDS*32-1:0]   result,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v
);

  localparam int W  = WORDS * 32;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          op_reg;
  logic          rev_reg;
  logic          use_carry_reg;
  logic          c_flag_reg;
  logic          carry_reg;

  // Split the captured operands into 32-bit words.
  logic [31:0] a_word [WORDS];
  logic [31:0] b_word [WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign a_word[gi] = a_reg[gi*32 +: 32];
      assign b_word[gi] = b_reg[gi*32 +: 32];
    end
  endgenerate

  logic [31:0] a_cur;
  logic [31:0] b_cur;
  logic        last_word;
  logic        low_zero;

  assign a_cur     = a_word[idx_reg];
  assign b_cur     = b_word[idx_reg];
  assign last_word = (idx_reg == LAST_IDX);
  // Every word except the top one is already in the result register at the last edge.
  assign low_zero  = ~|result[W-33:0];

  // Drive the shared adder. Word 0 uses the adder's own subtract mode.
  // Upper words use plain add with a sequencer-inverted operand, because the
  // adder ignores c_in in subtract mode and the chained carry must get through.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_c_in = 1'b0;
    add_op   = 1'b0;
    add_rev  = 1'b0;
    if (state_reg == RUN) begin
      if (idx_reg == '0) begin
        add_a    = a_cur;
        add_b    = b_cur;
        add_op   = op_reg;
        add_rev  = rev_reg;
        add_c_in = op_reg ? 1'b1 : (use_carry_reg & c_flag_reg);
      end else begin
        add_c_in = carry_reg;
        if (!op_reg) begin
          add_a = a_cur;
          add_b = b_cur;
        end else if (!rev_reg) begin
          add_a = a_cur;
          add_b = ~b_cur;
        end else begin
          add_a = b_cur;
          add_b = ~a_cur;
        end
      end
    end
  end

  // Sequencer state, operand capture, result assembly and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= 1'b0;
      rev_reg       <= 1'b0;
      use_carry_reg <= 1'b0;
      c_flag_reg    <= 1'b0;
      carry_reg     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      flag_n        <= 1'b0;
      flag_z        <= 1'b0;
      flag_c        <= 1'b0;
      flag_v        <= 1'b0;
    end else if (flush) begin
      // Abort: the result and flags stay as they are.
      state_reg <= IDLE;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        RUN: begin
          result[idx_reg*32 +: 32] <= add_s;
          carry_reg                <= add_c_out;
          if (last_word) begin
            state_reg <= DONE;
            done      <= 1'b1;
            flag_c    <= add_c_out;
            flag_n    <= add_s[31];
            flag_z    <= low_zero & ~|add_s;
            flag_v    <= (add_a[31] == add_b[31]) & (add_s[31] != add_a[31]);
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
          // IDLE, and the edge that ends DONE, can take a new request.
          if (start) begin
            state_reg     <= RUN;
            idx_reg       <= '0;
            a_reg         <= a_in;
            b_reg         <= b_in;
            op_reg        <= op;
            rev_reg       <= rev;
            use_carry_reg <= use_carry;
            c_flag_reg    <= c_flag_in;
            carry_reg     <= 1'b0;
            result        <= '0;
            busy          <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq. It models the external 32-bit adder,
// keeps a wide-arithmetic reference model, and compares the outputs on every done pulse.
module tb_mp_addsub_seq;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           op = 1'b0;
  logic           rev = 1'b0;
  logic           use_carry = 1'b0;
  logic           c_flag_in = 1'b0;
  logic           flush = 1'b0;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic [31:0]    add_a, add_b, add_s;
  logic           add_c_in, add_op, add_rev, add_c_out;
  logic           busy, done;
  logic [W-1:0]   result;
  logic           flag_n, flag_z, flag_c, flag_v;

  mp_addsub_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rev(rev),
    .use_carry(use_carry), .c_flag_in(c_flag_in), .flush(flush),
    .a_in(a_in), .b_in(b_in),
    .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in), .add_op(add_op),
    .add_rev(add_rev), .add_s(add_s), .add_c_out(add_c_out),
    .busy(busy), .done(done), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External adder: subtract mode forces carry-in to 1.
  always_comb begin
    logic [32:0] t;
    if (add_op)
      t = add_rev ? ({1'b0, add_b} + {1'b0, ~add_a} + 33'd1)
                  : ({1'b0, add_a} + {1'b0, ~add_b} + 33'd1);
    else
      t = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c_in};
    add_s     = t[31:0];
    add_c_out = t[32];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model on whole WORDS*32-bit numbers. Flags are packed as {N,Z,C,V}.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit o, input bit r, input bit uc, input bit cf,
                       output logic [W-1:0] res, output logic [3:0] f);
    logic [W:0]   full;
    logic [W-1:0] x, y;
    bit v;
    if (!o) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, uc & cf};
      v = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      x = r ? b : a;
      y = r ? a : b;
      full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      v = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
    end
    res = full[W-1:0];
    f   = {res[W-1], (res == '0), full[W], v};
  endtask

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  // Compare process: check every done pulse against the model, and check the adder is quiet when idle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending transaction");
        end else begin
          e = exp_q.pop_front();
          chk("model_result", result, e.r);
          chk("model_flags", W'({flag_n, flag_z, flag_c, flag_v}), W'(e.f));
          chk("latency", W'(cyc - e.acc), W'(WORDS));
          $display("txn acc=%0d result=%h nzcv=%b%b%b%b", e.acc, result,
                   flag_n, flag_z, flag_c, flag_v);
        end
      end
      if (!busy || done)
        chk("adder_quiet", W'({add_a, add_b, add_c_in, add_op, add_rev}), '0);
    end
  end

  // Wait for idle, then issue one request. Optionally queue its expected outcome.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit o, input bit r, input bit uc, input bit cf,
                       input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy=1 expected 0 within 100 cycles");
      return;
    end
    a_in = a; b_in = b; op = o; rev = r; use_carry = uc; c_flag_in = cf;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      model(a, b, o, r, uc, cf, e.r, e.f);
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < WORDS + 6; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected one within %0d cycles", WORDS + 6);
    end
  endtask

  // Directed case: pin the model to hand-computed values, then check the DUT against the same literals.
  task automatic run_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit o, input bit r, input bit uc, input bit cf,
                         input logic [W-1:0] er, input logic [3:0] ef);
    logic [W-1:0] mr;
    logic [3:0]   mf;
    bit seen;
    model(a, b, o, r, uc, cf, mr, mf);
    chk({nm, "_model_r"}, mr, er);
    chk({nm, "_model_f"}, W'(mf), W'(ef));
    do_op(a, b, o, r, uc, cf, 1'b1);
    wait_done(seen);
    if (seen) begin
      chk({nm, "_r"}, result, er);
      chk({nm, "_f"}, W'({flag_n, flag_z, flag_c, flag_v}), W'(ef));
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] x;
    x = '0;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       x[i*32 +: 32] = 32'd0;
        1:       x[i*32 +: 32] = 32'hFFFF_FFFF;
        default: x[i*32 +: 32] = $urandom;
      endcase
    end
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [W-1:0] ta, tb;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_result", result, '0);
    chk("reset_ctrl", W'({busy, done, flag_n, flag_z, flag_c, flag_v}), '0);
    chk("reset_adder", W'({add_a, add_b, add_c_in, add_op, add_rev}), '0);
    rst = 1'b0;

    // Directed vectors.
    run_lit("add_carry_chain", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1,
            1'b0, 1'b0, 1'b0, 1'b0, 128'h00000001_00000000_00000000_00000000, 4'b0000);
    run_lit("sub_equal", 128'h12345678_9ABCDEF0_0F0F0F0F_FFFFFFFF,
            128'h12345678_9ABCDEF0_0F0F0F0F_FFFFFFFF,
            1'b1, 1'b0, 1'b0, 1'b0, 128'd0, 4'b0110);
    run_lit("sub_borrow", 128'd0, 128'd1, 1'b1, 1'b0, 1'b0, 1'b0, {W{1'b1}}, 4'b1000);
    run_lit("sub_rev", 128'd0, 128'd1, 1'b1, 1'b1, 1'b0, 1'b0, 128'd1, 4'b0010);
    run_lit("overflow", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1,
            1'b0, 1'b0, 1'b0, 1'b0, 128'h80000000_00000000_00000000_00000000, 4'b1001);
    run_lit("adcs_c1", 128'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 128'd1, 4'b0000);
    run_lit("adcs_off", 128'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1, 128'd0, 4'b0100);

    // A second start during RUN is ignored.
    do_op(128'd5, 128'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a_in = rnd_operand(); b_in = rnd_operand(); op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_busy", W'(busy), W'(1));
    wait_done(seen);
    if (seen) chk("ignored_result", result, 128'd8);

    // Flush at idx=2: no done pulse, flags from the previous run (5+3 -> 0000) kept.
    do_op(128'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", W'({busy, done}), '0);
    chk("flush_flags", W'({flag_n, flag_z, flag_c, flag_v}), W'(4'b0000));
    repeat (8) @(negedge clk);
    chk("flush_stays_idle", W'(busy), '0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      ta = rnd_operand();
      tb = rnd_operand();
      do_op(ta, tb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", W'(exp_q.size()), '0);

    // Reset asserted at idx=1 clears everything immediately.
    do_op(rnd_operand(), rnd_operand(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_reset_result", result, '0);
    chk("midrun_reset_ctrl", W'({busy, done, flag_n, flag_z, flag_c, flag_v}), '0);
    chk("midrun_reset_adder", W'({add_a, add_b, add_c_in, add_op, add_rev}), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_reset_idle", W'(busy), '0);

    // Normal operation resumes after reset.
    run_lit("after_reset", 128'd5, 128'd3, 1'b0, 1'b0, 1'b0, 1'b0, 128'd8, 4'b0000);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
